// File: rtl/cordic_pkg.sv
// Shared types and constants for the folded CORDIC scheduler: FSM states, gain-compensated
// start amplitude and the arctangent table (angles scaled so 2^32 = 360 degrees).
package cordic_pkg;

  localparam int CORDIC_K = 19429;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] atan_lookup(input logic [4:0] i);
    logic [31:0] a;
    case (i)
      5'd0:  a = 32'h2000_0000;
      5'd1:  a = 32'h12E4_051D;
      5'd2:  a = 32'h09FB_385B;
      5'd3:  a = 32'h0511_11D4;
      5'd4:  a = 32'h028B_0D43;
      5'd5:  a = 32'h0145_D7E1;
      5'd6:  a = 32'h00A2_F61E;
      5'd7:  a = 32'h0051_7C55;
      5'd8:  a = 32'h0028_BE53;
      5'd9:  a = 32'h0014_5F2F;
      5'd10: a = 32'h000A_2F98;
      5'd11: a = 32'h0005_17CC;
      5'd12: a = 32'h0002_8BE6;
      5'd13: a = 32'h0001_45F3;
      5'd14: a = 32'h0000_A2F9;
      5'd15: a = 32'h0000_517C;
      5'd16: a = 32'h0000_28BE;
      5'd17: a = 32'h0000_145F;
      5'd18: a = 32'h0000_0A2F;
      5'd19: a = 32'h0000_0517;
      5'd20: a = 32'h0000_028B;
      5'd21: a = 32'h0000_0145;
      5'd22: a = 32'h0000_00A2;
      5'd23: a = 32'h0000_0051;
      5'd24: a = 32'h0000_0028;
      5'd25: a = 32'h0000_0014;
      5'd26: a = 32'h0000_000A;
      5'd27: a = 32'h0000_0005;
      5'd28: a = 32'h0000_0002;
      5'd29: a = 32'h0000_0001;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation; direction taken from the sign of the residual angle.
// Zero latency, no flow control; all shifts arithmetic, all sums wrap.
module cordic_microrot #(
  parameter int XW = 17,
  parameter int ZW = 32
) (
  input  logic signed [XW-1:0] x_in,
  input  logic signed [XW-1:0] y_in,
  input  logic signed [ZW-1:0] z_in,
  input  logic        [4:0]    shift,
  input  logic signed [ZW-1:0] atan,
  output logic signed [XW-1:0] x_out,
  output logic signed [XW-1:0] y_out,
  output logic signed [ZW-1:0] z_out
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x_in >>> shift;
  assign y_sh = y_in >>> shift;

  always_comb begin
    if (z_in[ZW-1]) begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan;
    end else begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan;
    end
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// Round-robin share of one folded CORDIC engine; grant to rsp_valid is ITERS+1 cycles, stalls only in DONE.
// Optional CORDIC_SIN_OUT_EN adds the registered sine output rsp_sin.
module cordic_rr_sched
  import cordic_pkg::*;
#(
  parameter int  N_REQ = 4,
  parameter int  ITERS = 15,
  parameter int  XW    = 17,
  parameter int  ZW    = 32,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*ZW-1:0]   req_angle,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic signed [15:0]    rsp_cos,
`ifdef CORDIC_SIN_OUT_EN
  output logic signed [15:0]    rsp_sin,
`endif
  output logic                  busy
);

  state_t               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_nx, y_nx;
  logic signed [ZW-1:0] z_q, z_d, z_nx;
  logic [4:0]           iter_q, iter_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx;
  logic signed [15:0]   cos_q, cos_d;
`ifdef CORDIC_SIN_OUT_EN
  logic signed [15:0]   sin_q, sin_d;
`endif
  logic                 gnt_vld;
  logic                 last_iter;
  logic [ZW-1:0]        angle_arr [N_REQ];
  logic [ZW-1:0]        gnt_angle;
  logic [ZW-1:0]        atan_i;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign angle_arr[gi] = req_angle[gi*ZW +: ZW];
  end

  // Descending scan so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'((int'(rr_ptr_q) + k) % N_REQ)]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  assign gnt_angle = angle_arr[gnt_idx];
  assign last_iter = (iter_q == 5'(ITERS - 1));
  assign atan_i    = ZW'(atan_lookup(iter_q) >> (32 - ZW));

  cordic_microrot #(.XW(XW), .ZW(ZW)) u_microrot (
    .x_in  (x_q),
    .y_in  (y_q),
    .z_in  (z_q),
    .shift (iter_q),
    .atan  (atan_i),
    .x_out (x_nx),
    .y_out (y_nx),
    .z_out (z_nx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld)   state_d = ITER;
      ITER:    if (last_iter) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // reset_n gate keeps req_ready low while reset is held with requests pending.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_vld && reset_n) req_ready[gnt_idx] = 1'b1;
    rsp_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    iter_d   = iter_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cos_d    = cos_q;
`ifdef CORDIC_SIN_OUT_EN
    sin_d    = sin_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d     = gnt_idx;
          rr_ptr_d = ID_W'((int'(gnt_idx) + 1) % N_REQ);
          iter_d   = '0;
          // Fold the angle into +-90 deg so the rotation sequence converges.
          case (gnt_angle[ZW-1 -: 2])
            2'b01: begin
              x_d = '0;
              y_d = XW'(CORDIC_K);
              z_d = {2'b00, gnt_angle[ZW-3:0]};
            end
            2'b10: begin
              x_d = '0;
              y_d = -XW'(CORDIC_K);
              z_d = {2'b11, gnt_angle[ZW-3:0]};
            end
            default: begin
              x_d = XW'(CORDIC_K);
              y_d = '0;
              z_d = gnt_angle;
            end
          endcase
        end
      end
      ITER: begin
        x_d    = x_nx;
        y_d    = y_nx;
        z_d    = z_nx;
        iter_d = iter_q + 5'd1;
        if (last_iter) begin
          cos_d = x_nx[15:0];
`ifdef CORDIC_SIN_OUT_EN
          sin_d = y_nx[15:0];
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter_q   <= '0;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cos_q    <= '0;
`ifdef CORDIC_SIN_OUT_EN
      sin_q    <= '0;
`endif
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      iter_q   <= iter_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cos_q    <= cos_d;
`ifdef CORDIC_SIN_OUT_EN
      sin_q    <= sin_d;
`endif
    end
  end

  assign rsp_id  = id_q;
  assign rsp_cos = cos_q;
`ifdef CORDIC_SIN_OUT_EN
  assign rsp_sin = sin_q;
`endif

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: a cycle-level model (phase + countdown, math-library cosine)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cordic_rr_sched;

  localparam int N     = 4;
  localparam int ITERS = 15;
  localparam int TOL   = 16;
  localparam int TOL_M = 24;

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_angle;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic signed [15:0] rsp_cos;
`ifdef CORDIC_SIN_OUT_EN
  logic signed [15:0] rsp_sin;
  int            last_sin;
`endif
  logic          busy;

  int n_tests = 0;
  int n_fails = 0;
  int cyc = 0;
  int last_cos, last_id, last_lat;
  int gnt_log[$];

  logic [31:0] q_ang [4] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h2000_0000};
  int          q_exp [4] = '{0, -32000, 0, 22627};

  cordic_rr_sched #(.N_REQ(N), .ITERS(ITERS), .XW(17), .ZW(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_angle (req_angle),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cos   (rsp_cos),
`ifdef CORDIC_SIN_OUT_EN
    .rsp_sin   (rsp_sin),
`endif
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    n_tests++;
    if (act > exp + tol || act < exp - tol) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d +-%0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic real theta(input logic [31:0] a);
    return 6.283185307179586 * real'(a) / 4294967296.0;
  endfunction

  function automatic int exp_cos(input logic [31:0] a);
    return int'(32000.0 * $cos(theta(a)));
  endfunction

  function automatic int exp_sin(input logic [31:0] a);
    return int'(32000.0 * $sin(theta(a)));
  endfunction

  // Reference model: phase 0 idle, 1 rotating (countdown), 2 result held.
  initial begin
    int ph, rem, m_ptr, m_id, held, g;
    bit first;
    logic [31:0] m_ang;
    logic [N-1:0] exp_rdy;
    ph = 0; rem = 0; m_ptr = 0; m_id = 0; held = 0; first = 1'b0; m_ang = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("m_rst_ready", int'(req_ready), 0);
        chk("m_rst_rsp_valid", int'(rsp_valid), 0);
        chk("m_rst_busy", int'(busy), 0);
        chk("m_rst_id", int'(rsp_id), 0);
        chk("m_rst_cos", int'(rsp_cos), 0);
`ifdef CORDIC_SIN_OUT_EN
        chk("m_rst_sin", int'(rsp_sin), 0);
`endif
        ph = 0;
        m_ptr = 0;
      end else begin
        case (ph)
          0: begin
            g = pick(req_valid, m_ptr);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("m_idle_ready", int'(req_ready), int'(exp_rdy));
            chk("m_idle_rsp_valid", int'(rsp_valid), 0);
            chk("m_idle_busy", int'(busy), 0);
            if (g >= 0) begin
              m_id  = g;
              m_ang = req_angle[g*32 +: 32];
              m_ptr = (g + 1) % N;
              rem   = ITERS;
              ph    = 1;
              gnt_log.push_back(g);
            end
          end
          1: begin
            chk("m_run_ready", int'(req_ready), 0);
            chk("m_run_rsp_valid", int'(rsp_valid), 0);
            chk("m_run_busy", int'(busy), 1);
            rem--;
            if (rem == 0) begin
              ph = 2;
              first = 1'b1;
            end
          end
          default: begin
            chk("m_done_rsp_valid", int'(rsp_valid), 1);
            chk("m_done_busy", int'(busy), 1);
            chk("m_done_ready", int'(req_ready), 0);
            chk("m_done_id", int'(rsp_id), m_id);
            chk_near("m_done_cos", int'(rsp_cos), exp_cos(m_ang), TOL_M);
`ifdef CORDIC_SIN_OUT_EN
            chk_near("m_done_sin", int'(rsp_sin), exp_sin(m_ang), TOL_M);
`endif
            if (!first) chk("m_done_cos_stable", int'(rsp_cos), held);
            held  = int'(rsp_cos);
            first = 1'b0;
            if (rsp_ready) ph = 0;
          end
        endcase
      end
    end
  end

  task automatic wait_idle(input string tag, input int max);
    bit ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle_timeout"}, int'(ok), 1);
  endtask

  task automatic do_req(input int idx, input logic [31:0] ang, input string tag);
    int c0;
    bit ok;
    @(posedge clock); #1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_angle[idx*32 +: 32] = ang;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_grant_timeout"}, int'(ok), 1);
    c0 = cyc;
    @(posedge clock); #1;
    req_valid = '0;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_rsp_timeout"}, int'(ok), 1);
    last_lat = cyc - c0;
    last_cos = int'(rsp_cos);
    last_id  = int'(rsp_id);
`ifdef CORDIC_SIN_OUT_EN
    last_sin = int'(rsp_sin);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset_n   = 1'b0;
    req_valid = 4'b0101;
    req_angle = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_cos", int'(rsp_cos), 0);
    chk("rst_id", int'(rsp_id), 0);
    req_valid = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Single request at angle 0.
    do_req(0, 32'h0000_0000, "t1");
    chk("t1_id", last_id, 0);
    chk_near("t1_cos", last_cos, 32000, TOL);
    chk("t1_latency", last_lat, ITERS + 1);
    wait_idle("t1", 10);

    // Quadrant sweep.
    for (int k = 0; k < 4; k++) begin
      do_req(k, q_ang[k], $sformatf("t2_%0d", k));
      chk($sformatf("t2_id_%0d", k), last_id, k);
      chk_near($sformatf("t2_cos_%0d", k), last_cos, q_exp[k], TOL);
      wait_idle("t2", 10);
    end

    // All requesters valid continuously from reset.
    @(posedge clock); #1;
    reset_n = 1'b0;
    gnt_log.delete();
    req_valid = 4'hF;
    req_angle = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clock);
      if (gnt_log.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t3_grant_timeout", int'(ok), 1);
    for (int k = 0; k < 5; k++)
      if (k < gnt_log.size()) chk($sformatf("t3_grant_%0d", k), gnt_log[k], k % 4);
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle("t3", 40);

    // Back-pressure: result held for 10 cycles while other requesters wait.
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    do_req(2, 32'h6000_0000, "t4");
    chk_near("t4_cos", last_cos, -22627, TOL);
    @(posedge clock); #1;
    req_valid = 4'b1011;
    repeat (10) @(negedge clock);
    chk("t4_hold_valid", int'(rsp_valid), 1);
    chk("t4_hold_cos", int'(rsp_cos), last_cos);
    chk("t4_hold_id", int'(rsp_id), 2);
    chk("t4_hold_ready", int'(req_ready), 0);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("t4_after_busy", int'(busy), 0);
    chk("t4_next_grant", int'(req_ready), 4'b1000);
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle("t4", 40);

    // Reset five cycles into the rotation.
    @(posedge clock); #1;
    req_valid = 4'b0010;
    req_angle[32 +: 32] = 32'h1234_5678;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (req_ready[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_grant_timeout", int'(ok), 1);
    @(posedge clock); #1;
    req_valid = '0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_rsp_valid", int'(rsp_valid), 0);
    chk("t5_id", int'(rsp_id), 0);
    chk("t5_cos", int'(rsp_cos), 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("t5_no_stale_rsp", int'(rsp_valid), 0);
    @(posedge clock); #1;
    req_valid = 4'b1110;
    @(negedge clock);
    chk("t5_ptr_zero_grant", int'(req_ready), 4'b0010);
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle("t5", 40);

`ifdef CORDIC_SIN_OUT_EN
    do_req(3, 32'h4000_0000, "t6");
    chk_near("t6_sin", last_sin, 32000, TOL);
    wait_idle("t6", 10);
`endif

    // Randomized traffic with random back-pressure.
    for (int k = 0; k < 400; k++) begin
      @(posedge clock); #1;
      req_valid = 4'($urandom_range(0, 15));
      req_angle = {$urandom, $urandom, $urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand", 40);
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
